serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 15 +
 rtl/diff_cell.sv | 16 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Subtraction is a + ~b + 1, so the serial carry starts at one.
    localparam logic SUB_CARRY_INIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/diff_cell.sv
// One-bit difference cell: x - y using an active-low-borrow carry.
module diff_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic d,
    output logic cout
);

    logic yn;

    assign yn   = ~y;
    assign d    = x ^ yn ^ cin;
    assign cout = (x & yn) | (x & cin) | (yn & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             cell_d, cell_cout;

    diff_cell u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .cin  (carry_q),
        .d    (cell_d),
        .cout (cell_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = SUB_CARRY_INIT;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                res_d   = {cell_d, res_q[WIDTH-1:1]};
                carry_d = cell_cout;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Latch results on the final bit so they show in DONE.
                if (cnt_q == LAST) begin
                    diff_d   = res_d;
                    borrow_d = ~cell_cout;
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a cycle-level model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow, overflow;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int d;
        d = int'($signed(x)) - int'($signed(y));
        return (d > 127) || (d < -128);
    endfunction

    // Model: ph counts remaining busy cycles after an accepted start.
    int           ph = 0;
    logic [W-1:0] m_diff = '0, e_diff = '0;
    logic         m_b = 1'b0, m_o = 1'b0, e_b = 1'b0, e_o = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ph     <= 0;
            m_diff <= '0;
            m_b    <= 1'b0;
            m_o    <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph     <= W + 1;
                e_diff <= a - b;
                e_b    <= (a < b);
                e_o    <= sovf(a, b);
            end
        end else begin
            if (ph == 2) begin
                m_diff <= e_diff;
                m_b    <= e_b;
                m_o    <= e_o;
            end
            ph <= ph - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy", 32'(busy), 32'(ph > 0));
            chk("cmp_done", 32'(done), 32'(ph == 1));
            chk("cmp_diff", 32'(diff), 32'(m_diff));
            chk("cmp_borrow", 32'(borrow), 32'(m_b));
            chk("cmp_ovf", 32'(overflow), 32'(m_o));
        end
    end

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [W-1:0] xd, input logic xb,
                          input logic xo, input string nm);
        int n;
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'd9);
        chk({nm, "_diff"}, 32'(diff), 32'(xd));
        chk({nm, "_borrow"}, 32'(borrow), 32'(xb));
        chk({nm, "_ovf"}, 32'(overflow), 32'(xo));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dn, first_n, k, c;
        int t[3];
        logic [W-1:0] pa[3], pb[3], pd[3];

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, "op35_12");
        run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, "op12_35");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "op00_00");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "op80_01");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "op7F_FF");

        // start while busy is ignored; operands may change mid-op
        start   = 1'b1;
        a       = 8'h50;
        b       = 8'h20;
        dn      = 0;
        first_n = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                first_n = n;
            end
            case (n)
                1: start = 1'b0;
                3: begin start = 1'b1; a = 8'h01; b = 8'h01; end
                4: begin start = 1'b0; a = 8'hFF; b = 8'h77; end
                9: start = 1'b1;
                10: start = 1'b0;
                default: ;
            endcase
        end
        chk("busy_ign_count", 32'(dn), 32'd1);
        chk("busy_ign_lat", 32'(first_n), 32'd9);
        chk("busy_ign_diff", 32'(diff), 32'h30);

        // reset on the 4th SHIFT cycle aborts the operation
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        reset = 1'b0;
        run_op(8'h0A, 8'h03, 8'h07, 1'b0, 1'b0, "op0A_03");

        // continuous start: back-to-back operations
        pa[0] = 8'h10; pb[0] = 8'h01; pd[0] = 8'h0F;
        pa[1] = 8'h01; pb[1] = 8'h10; pd[1] = 8'hF1;
        pa[2] = 8'hC0; pb[2] = 8'h40; pd[2] = 8'h80;
        k     = 0;
        start = 1'b1;
        a     = pa[0];
        b     = pb[0];
        for (c = 1; c <= 60 && k < 3; c++) begin
            @(negedge clk);
            if (done) begin
                t[k] = c;
                chk("cont_diff", 32'(diff), 32'(pd[k]));
                k++;
                if (k == 3) start = 1'b0;
                else begin
                    a = pa[k];
                    b = pb[k];
                end
            end
        end
        start = 1'b0;
        chk("cont_count", 32'(k), 32'd3);
        if (k == 3) begin
            chk("cont_gap1", 32'(t[1] - t[0]), 32'd10);
            chk("cont_gap2", 32'(t[2] - t[1]), 32'd10);
        end
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
